tela_resultado: RTL

End-of-match result screen renderer that succeeds the fixed victory overlay. It draws a scaled SPR_W×SPR_H monochrome sprite at a parametrised position, with the pattern and colour selected by match outcome. A frame-driven FSM holds the sprite solid, then blinks it. It sits after the VGA timing generator, driven by the same h_counter/v_counter, and its RGB goes to the screen mux.

---
 rtl/tela_pkg.sv | 50 +++++
 rtl/sprite_rom.sv | 33 +++
 rtl/tela_resultado.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tela_pkg.sv
// Shared definitions for the result-screen renderer: FSM encoding,
// victory sprite bitmap and a colour split helper.
package tela_pkg;

  // FSM encoding for the result screen sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  // Sprite bitmap is a fixed 11x11 pattern; 4 bits index a row or column
  localparam int unsigned SPR_DIM = 11;
  localparam int unsigned IDX_W   = 4;

  // Frame counter width, wide enough for long show/blink periods
  localparam int unsigned CNT_W = 16;

  // One pixel colour broken into its channels
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Victory bitmap, row 0 at the top, bit c of a row is sprite column c
  localparam logic [0:10][10:0] VIC_ROWS = {
    11'h020,  // r0 : col 5
    11'h070,  // r1 : cols 4-6
    11'h0F8,  // r2 : cols 3-7
    11'h1DC,  // r3 : cols 2-4, 6-8
    11'h38E,  // r4 : cols 1-3, 7-9
    11'h7FF,  // r5 : full row
    11'h7FF,  // r6
    11'h7FF,  // r7
    11'h7FF,  // r8
    11'h104,  // r9 : cols 2, 8
    11'h104   // r10: cols 2, 8
  };

  // Split a packed {R,G,B} colour into channels
  function automatic rgb_t split_rgb(input logic [23:0] c);
    rgb_t o;
    o.r = c[23:16];
    o.g = c[15:8];
    o.b = c[7:0];
    return o;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap lookup; defeat (mode=1) reads the victory rows upside down.
module sprite_rom
  import tela_pkg::*;
(
  input  logic             mode,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic             pix_bit
);

  logic [IDX_W-1:0] row_eff_s;

  // Vertical mirroring for the defeat pattern
  always_comb begin
    row_eff_s = row;
    if (mode) begin
      row_eff_s = IDX_W'(SPR_DIM - 1) - row;
    end else begin
      row_eff_s = row;
    end
  end

  // Bitmap read, anything outside the 11x11 grid is clear
  always_comb begin
    pix_bit = 1'b0;
    if ((row <= IDX_W'(SPR_DIM - 1)) && (col <= IDX_W'(SPR_DIM - 1))) begin
      pix_bit = VIC_ROWS[row_eff_s][col];
    end else begin
      pix_bit = 1'b0;
    end
  end

endmodule

// File: rtl/tela_resultado.sv
// End-of-match result screen: draws a scaled victory/defeat sprite,
// holds it solid for a number of frames and then blinks it.
// Pixel path is two registered stages from h/v_counter to R/G/B.
module tela_resultado
  import tela_pkg::*;
#(
  parameter int unsigned SCALE        = 6,
  parameter int unsigned SPR_W        = 11,
  parameter int unsigned SPR_H        = 11,
  parameter int unsigned POS_X        = 400,
  parameter int unsigned POS_Y        = 250,
  parameter int unsigned SHOW_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [23:0] FG_VIC       = 24'hFFFFFF,
  parameter logic [23:0] FG_DEF       = 24'hFF0000,
  parameter logic [23:0] BG           = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       active
);

  localparam int unsigned X_END = POS_X + SPR_W * SCALE;
  localparam int unsigned Y_END = POS_Y + SPR_H * SCALE;

  // ---------------- frame tick ----------------
  logic origin_s;
  logic origin_r;
  logic tick_s;

  assign origin_s = (h_counter == 10'd0) && (v_counter == 10'd0);
  assign tick_s   = origin_s && !origin_r;

  // Remember last clk's origin condition so a held origin yields one tick
  always_ff @(posedge clk) begin
    if (reset) begin
      origin_r <= 1'b0;
    end else begin
      origin_r <= origin_s;
    end
  end

  // ---------------- sequencer ----------------
  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] frame_cnt_n;
  logic             vis_r;
  logic             vis_n;
  logic             mode_r;
  logic             mode_n;
  logic             active_r;

  // Next-state logic; dropping enable always wins over a tick
  always_comb begin
    state_n     = state_r;
    frame_cnt_n = frame_cnt_r;
    vis_n       = vis_r;
    mode_n      = mode_r;
    case (state_r)
      ST_IDLE: begin
        frame_cnt_n = {CNT_W{1'b0}};
        vis_n       = 1'b0;
        if (tick_s && enable) begin
          state_n = ST_SHOW;
          mode_n  = mode;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_n     = ST_IDLE;
          frame_cnt_n = {CNT_W{1'b0}};
          vis_n       = 1'b0;
        end else if (tick_s) begin
          if (frame_cnt_r == CNT_W'(SHOW_FRAMES - 1)) begin
            state_n     = ST_BLINK;
            frame_cnt_n = {CNT_W{1'b0}};
            vis_n       = 1'b0;
          end else begin
            frame_cnt_n = frame_cnt_r + CNT_W'(1);
          end
        end else begin
          state_n = ST_SHOW;
        end
      end
      ST_BLINK: begin
        if (!enable) begin
          state_n     = ST_IDLE;
          frame_cnt_n = {CNT_W{1'b0}};
          vis_n       = 1'b0;
        end else if (tick_s) begin
          if (frame_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_n = {CNT_W{1'b0}};
            vis_n       = !vis_r;
          end else begin
            frame_cnt_n = frame_cnt_r + CNT_W'(1);
          end
        end else begin
          state_n = ST_BLINK;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        frame_cnt_n = {CNT_W{1'b0}};
        vis_n       = 1'b0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= {CNT_W{1'b0}};
      vis_r       <= 1'b0;
      mode_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      frame_cnt_r <= frame_cnt_n;
      vis_r       <= vis_n;
      mode_r      <= mode_n;
    end
  end

  // active trails the state by one clk
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= 1'b0;
    end else begin
      active_r <= (state_r != ST_IDLE);
    end
  end

  assign active = active_r;

  // ---------------- pixel stage 1: window and sprite coordinates ----------------
  logic [31:0]      h_ext_s;
  logic [31:0]      v_ext_s;
  logic             win_s;
  logic [IDX_W-1:0] col_s;
  logic [IDX_W-1:0] row_s;
  logic             win_r;
  logic [IDX_W-1:0] col_r;
  logic [IDX_W-1:0] row_r;

  assign h_ext_s = {22'd0, h_counter};
  assign v_ext_s = {22'd0, v_counter};

  // Window test (lower bound inclusive, upper exclusive) and scaled coordinates
  always_comb begin
    win_s = (h_ext_s >= 32'(POS_X)) && (h_ext_s < 32'(X_END)) &&
            (v_ext_s >= 32'(POS_Y)) && (v_ext_s < 32'(Y_END));
    col_s = {IDX_W{1'b0}};
    row_s = {IDX_W{1'b0}};
    if (win_s) begin
      col_s = IDX_W'((h_ext_s - 32'(POS_X)) / 32'(SCALE));
      row_s = IDX_W'((v_ext_s - 32'(POS_Y)) / 32'(SCALE));
    end else begin
      col_s = {IDX_W{1'b0}};
      row_s = {IDX_W{1'b0}};
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      win_r <= 1'b0;
      col_r <= {IDX_W{1'b0}};
      row_r <= {IDX_W{1'b0}};
    end else begin
      win_r <= win_s;
      col_r <= col_s;
      row_r <= row_s;
    end
  end

  // ---------------- pixel stage 2: lookup and colour select ----------------
  logic rom_bit_s;
  logic pix_on_s;
  rgb_t fg_s;
  rgb_t rgb_r;

  sprite_rom u_rom (
    .mode    (mode_r),
    .row     (row_r),
    .col     (col_r),
    .pix_bit (rom_bit_s)
  );

  // Visibility uses the state as it stands this clk; latched mode picks the colour
  always_comb begin
    pix_on_s = 1'b0;
    fg_s     = split_rgb(FG_VIC);
    if (mode_r) begin
      fg_s = split_rgb(FG_DEF);
    end else begin
      fg_s = split_rgb(FG_VIC);
    end
    if (state_r == ST_IDLE) begin
      pix_on_s = 1'b0;
    end else begin
      pix_on_s = win_r && rom_bit_s && ((state_r == ST_SHOW) || vis_r);
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r <= split_rgb(BG);
    end else if (pix_on_s) begin
      rgb_r <= fg_s;
    end else begin
      rgb_r <= split_rgb(BG);
    end
  end

  assign R = rgb_r.r;
  assign G = rgb_r.g;
  assign B = rgb_r.b;

endmodule
